uart_core: RTL
==============

Name: uart_core

Overview:
- Parametrised full-duplex UART: one transmitter and one receiver on a single clock.
- TX takes words over a valid/ready handshake. RX delivers words through a small FIFO with per-word error flags.
- Generalises the fixed 8N1 button/LED UART: configurable data width, parity, stop bits and RX buffering.
- Sits between board pins and any byte-stream client (command parser, memory dumper).

Parameters:
- CLKS_PER_BIT, 234, clock cycles per bit (27 MHz / 115200); minimum 8.
- DATA_BITS, 8, data bits per frame; legal 5..8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits transmitted; legal 1 or 2. RX always checks only the first.
- RX_FIFO_DEPTH, 4, RX FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial input, asynchronous to clk.
- uart_tx  out  1  serial output; idles high.
- tx_data  in  DATA_BITS  word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter can accept a word.
- rx_data  out  DATA_BITS  FIFO head data.
- rx_frame_err  out  1  FIFO head: stop bit sampled low.
- rx_parity_err  out  1  FIFO head: parity mismatch (always 0 when PARITY = 0).
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer pops the head.
- rx_overrun  out  1  one-cycle pulse: a received word was dropped because the FIFO was full.

Behaviour:
- Reset, asynchronous:
  - uart_tx = 1, tx_ready = 1, rx_valid = 0, rx_overrun = 0.
  - rx_data and error flags = 0; FIFO emptied; both FSMs to IDLE; counters = 0.
  - A frame in flight is abandoned, and the line is high immediately.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - tx_ready = 1 only in IDLE. A word is accepted when tx_valid and tx_ready are both 1 at a clock edge; tx_data is latched.
  - uart_tx is registered and goes low on the cycle after acceptance.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Bit order: start (0), then data LSB first for DATA_BITS bits, then parity if PARITY != 0, then STOP_BITS stop bits (1).
  - Odd parity makes the count of ones over data plus parity odd; even parity makes it even.
  - After the last stop-bit cycle the FSM returns to IDLE and uart_tx stays 1.
  - Back-to-back words therefore have exactly one extra idle-high cycle between frames.
  - tx_data changes while busy are ignored.
- RX synchroniser: uart_rx passes through a 2-flop synchroniser, which is reset to 1. All RX timing below uses the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE to START on a sampled 0; counter starts.
  - START: at count CLKS_PER_BIT/2 (integer division), re-sample the line.
    - If 1, it is a glitch: return to IDLE and push nothing.
    - If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, which lands at bit centres. Shift in LSB first. After DATA_BITS samples go to PARITY, or to STOP if PARITY = 0.
  - PARITY: sample at the bit centre and compare with the parity computed over the received data.
  - STOP: sample at the centre of the first stop bit. frame_err = (sample == 0). Push {parity_err, frame_err, data} and return to IDLE in the same cycle.
  - A line held low (break) therefore yields data 0 with frame_err = 1, then waits in IDLE for the line to go high, then low again.
- RX FIFO:
  - rx_valid rises the cycle after the push. rx_data and flags always reflect the head entry.
  - A pop happens when rx_valid and rx_ready are both 1 at an edge.
  - Push while full and no pop in that cycle: the word is dropped, the FIFO is unchanged, and rx_overrun pulses for 1 cycle.
  - Push while full with a pop in the same cycle: both take effect and no overrun occurs.
  - Push while empty with a pop in the same cycle: the pop is impossible because rx_valid = 0.
  - Pointers wrap modulo RX_FIFO_DEPTH. Occupancy uses log2(RX_FIFO_DEPTH)+1 bits.
- Counters are sized to hold CLKS_PER_BIT-1 and compare with ==. No arithmetic overflow is possible.

Test Plan:
- Frame format: CLKS_PER_BIT=16, 8N1, send 0x55 -> uart_tx low for 16 cycles, then 0,1,0,1,0,1,0,1 alternating as 1,0,1,0,1,0,1,0 LSB-first, each 16 cycles, then high 16 cycles. tx_ready returns after 160 cycles.
- Parity and stop bits: DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x03 -> parity bit 0, two stop bits. Frame length = 11 bits = 176 cycles. Loopback uart_tx to uart_rx -> rx_data 0x03, no errors.
- Errors: inject 8O1 frame 0xA5 with the parity bit flipped -> rx_parity_err = 1. Inject a frame with stop bit 0 -> rx_frame_err = 1, data still captured.
- Glitch rejection: 5-cycle low pulse on uart_rx -> no push, RX back in IDLE, next valid frame 0x3C received correctly.
- Overrun: RX_FIFO_DEPTH=4, rx_ready=0, receive 5 bytes 0x10..0x14 -> 5th drops and rx_overrun pulses once. Popping returns 0x10..0x13. Repeat with rx_ready pulsed on the 5th push cycle -> no overrun.
- Reset: assert rst mid-TX-data-bit and mid-RX-frame -> uart_tx = 1 and tx_ready = 1 immediately, rx_valid = 0. After deassert, the next 0xC3 transfers in both directions.

Source files
------------

// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART. Registered TX FSM, RX FSM behind a
// 2-flop synchroniser, and a small RX FIFO carrying per-word error flags.
module uart_core #(
  parameter int unsigned CLKS_PER_BIT  = 234,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun
);
  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned AddrW = $clog2(RX_FIFO_DEPTH);
  localparam logic [CntW-1:0]  CntLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0]  CntMid   = CntW'(CLKS_PER_BIT / 2);
  localparam logic [2:0]       DataLast = 3'(DATA_BITS - 1);
  localparam logic [2:0]       StopLast = 3'(STOP_BITS - 1);
  localparam logic [AddrW:0]   FifoFull = (AddrW + 1)'(RX_FIFO_DEPTH);
  localparam logic             OddPar   = (PARITY == 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------- transmitter ----------------
  state_e                 tx_state_q, tx_state_d;
  logic [CntW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]             tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic                   tx_par_q, tx_par_d;
  logic                   tx_line_q, tx_line_d;
  logic                   tx_at_last;

  assign uart_tx    = tx_line_q;
  assign tx_ready   = (tx_state_q == StIdle);
  assign tx_at_last = (tx_cnt_q == CntLast);

  // TX state register; reset forces the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // TX next state; the line register is loaded with the value of the bit being entered.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_at_last ? '0 : tx_cnt_q + 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      StIdle: begin
        tx_cnt_d = '0;
        if (tx_valid) begin
          tx_shift_d = tx_data;
          tx_par_d   = (^tx_data) ^ OddPar;
          tx_line_d  = 1'b0;
          tx_state_d = StStart;
        end
      end
      StStart: if (tx_at_last) begin
        tx_bit_d   = '0;
        tx_line_d  = tx_shift_q[0];
        tx_state_d = StData;
      end
      StData: if (tx_at_last) begin
        if (tx_bit_q == DataLast) begin
          tx_bit_d = '0;
          if (PARITY != 0) begin
            tx_line_d  = tx_par_q;
            tx_state_d = StParity;
          end else begin
            tx_line_d  = 1'b1;
            tx_state_d = StStop;
          end
        end else begin
          tx_bit_d   = tx_bit_q + 1'b1;
          tx_line_d  = tx_shift_q[1];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      StParity: if (tx_at_last) begin
        tx_line_d  = 1'b1;
        tx_state_d = StStop;
      end
      StStop: if (tx_at_last) begin
        if (tx_bit_q == StopLast) tx_state_d = StIdle;
        else                      tx_bit_d   = tx_bit_q + 1'b1;
      end
      default: tx_state_d = StIdle;
    endcase
  end

  // ---------------- receiver ----------------
  logic [1:0]             sync_q;
  logic                   rx_s, rx_prev_q;
  state_e                 rx_state_q, rx_state_d;
  logic [CntW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]             rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic                   rx_perr_q, rx_perr_d;
  logic                   rx_at_last, rx_push, rx_push_ferr;

  assign rx_s       = sync_q[1];
  assign rx_at_last = (rx_cnt_q == CntLast);

  // Synchroniser and RX state register; the edge detector starts from idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], uart_rx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  // RX next state; a start needs a high-to-low edge so a held break line is not re-framed.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_at_last ? '0 : rx_cnt_q + 1'b1;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    rx_perr_d    = rx_perr_q;
    rx_push      = 1'b0;
    rx_push_ferr = 1'b0;
    case (rx_state_q)
      StIdle: begin
        rx_cnt_d = '0;
        if (!rx_s && rx_prev_q) begin
          rx_perr_d  = 1'b0;
          rx_state_d = StStart;
        end
      end
      StStart: if (rx_cnt_q == CntMid) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s ? StIdle : StData;
      end
      StData: if (rx_at_last) begin
        rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
        if (rx_bit_q == DataLast) rx_state_d = (PARITY != 0) ? StParity : StStop;
        else                      rx_bit_d   = rx_bit_q + 1'b1;
      end
      StParity: if (rx_at_last) begin
        rx_perr_d  = rx_s ^ (^rx_shift_q) ^ OddPar;
        rx_state_d = StStop;
      end
      StStop: if (rx_at_last) begin
        rx_push      = 1'b1;
        rx_push_ferr = ~rx_s;
        rx_state_d   = StIdle;
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS+1:0] mem_q [RX_FIFO_DEPTH];
  logic [AddrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]       count_q, count_d;
  logic                 pop, full, wr_en, overrun_q;

  assign pop        = rx_valid & rx_ready;
  assign full       = (count_q == FifoFull);
  assign wr_en      = rx_push & (~full | pop);
  assign rx_valid   = (count_q != '0);
  assign rx_overrun = overrun_q;
  assign {rx_parity_err, rx_frame_err, rx_data} = mem_q[rd_ptr_q];

  // Occupancy update; a pop in the same cycle makes room for a push into a full FIFO.
  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  // FIFO storage and pointers; entries are cleared so the head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= rx_push & full & ~pop;
      count_q   <= count_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {rx_perr_q, rx_push_ferr, rx_shift_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule
